// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost flags, read-valid strobe and sticky error flags.
// Define FIFO_FLAGGED_HWM_EN to build the max_count high-water-mark register (tied to 0 otherwise).
module fifo_flagged #(
   parameter int DATA_WIDTH    = 64,
   parameter int DEPTH         = 1024,
   parameter int AFULL_THRESH  = DEPTH - 4,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [DATA_WIDTH-1:0]      din,
   input  logic                       re,
   output logic [DATA_WIDTH-1:0]      dout,
   output logic                       dout_valid,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_empty,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err,
   output logic [$clog2(DEPTH):0]     max_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("fifo_flagged: DEPTH must be a power of two and >= 2");
   end
   if (!(AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
      $error("fifo_flagged: need AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         waddr;
   logic [AW-1:0]         raddr;
   logic [CW-1:0]         count_next;
   logic                  rd_ok;
   logic                  wr_ok;

   assign empty        = (count == '0);
   assign full         = (count == CW'(DEPTH));
   assign almost_empty = (count <= CW'(AEMPTY_THRESH));
   assign almost_full  = (count >= CW'(AFULL_THRESH));

   // No fall-through: a read on an empty FIFO is rejected even if a write lands this cycle.
   assign rd_ok = re && !empty;
   assign wr_ok = we && (!full || rd_ok);

   always_comb begin
      count_next = count;
      case ({wr_ok, rd_ok})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   // Storage array kept free of reset so it maps onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_ok) mem[waddr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr      <= '0;
         raddr      <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         count      <= count_next;
         dout_valid <= rd_ok;
         if (wr_ok) waddr <= waddr + AW'(1);
         if (rd_ok) begin
            raddr <= raddr + AW'(1);
            dout  <= mem[raddr];
         end
      end
   end

   // Sticky error flags; clear wins over a same-cycle set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clr_err) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (we && !wr_ok) overflow  <= 1'b1;
         if (re && !rd_ok) underflow <= 1'b1;
      end
   end

`ifdef FIFO_FLAGGED_HWM_EN
   // Clearing restarts the mark from the occupancy the FIFO will hold next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          max_count <= '0;
      else if (clr_err)                 max_count <= count_next;
      else if (count_next > max_count)  max_count <= count_next;
   end
`else
   assign max_count = '0;
`endif

endmodule
